// File: rtl/npu_pkg.sv
// Shared NPU definitions: layer sequencer state encoding and accumulator width.
package npu_pkg;

    localparam int ACC_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREP    = 3'd1,
        LOAD    = 3'd2,
        STREAM  = 3'd3,
        CAPTURE = 3'd4,
        FINISH  = 3'd5
    } state_t;

endpackage

// File: rtl/neuron_layer_seq_if.sv
// Control/result bundle between the layer sequencer and its surroundings
// (operand memories, shared MAC, host). The sequencer side is the master.
interface neuron_layer_seq_if #(
    parameter int XAW = 10,
    parameter int NAW = 4,
    parameter int WAW = 13
) ();
    import npu_pkg::*;

    logic             START;
    logic             BUSY;
    logic             DONE;
    logic [XAW-1:0]   X_ADDR;
    logic [WAW-1:0]   W_ADDR;
    logic [NAW-1:0]   BIAS_ADDR;
    logic             RST_MAC;
    logic             EN_MAC;
    logic [ACC_W-1:0] MAC_RESULT;
    logic             NEURON_VALID;
    logic [NAW-1:0]   NEURON_IDX;
    logic [ACC_W-1:0] NEURON_SUM;
    logic [NAW-1:0]   CLASS_OUT;
    logic [ACC_W-1:0] MAX_OUT;

    modport master (
        input  START, MAC_RESULT,
        output BUSY, DONE, X_ADDR, W_ADDR, BIAS_ADDR, RST_MAC, EN_MAC,
               NEURON_VALID, NEURON_IDX, NEURON_SUM, CLASS_OUT, MAX_OUT
    );

    modport slave (
        output START, MAC_RESULT,
        input  BUSY, DONE, X_ADDR, W_ADDR, BIAS_ADDR, RST_MAC, EN_MAC,
               NEURON_VALID, NEURON_IDX, NEURON_SUM, CLASS_OUT, MAX_OUT
    );

endinterface

// File: rtl/argmax_tracker.sv
// Running argmax over neuron sums. The outputs already include the sum being
// presented this cycle, so a caller can register the final winner on the same
// edge that the last sum is absorbed. Ties keep the earlier (lower) index.
module argmax_tracker
    import npu_pkg::*;
#(
    parameter int IW = 4,
    parameter int VW = ACC_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          valid,
    input  logic [IW-1:0] idx,
    input  logic [VW-1:0] value,
    output logic [IW-1:0] best_idx,
    output logic [VW-1:0] best_val
);

    logic          have_r;
    logic [IW-1:0] idx_r;
    logic [VW-1:0] val_r;
    logic          take_s;

    // First sum after a clear is taken unconditionally, later only if strictly larger.
    always_comb begin
        take_s = 1'b0;
        if (valid) begin
            take_s = !have_r || (value > val_r);
        end else begin
            take_s = 1'b0;
        end
    end

    assign best_idx = take_s ? idx   : idx_r;
    assign best_val = take_s ? value : val_r;

    // Best-so-far registers, cleared at the start of each layer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            have_r <= 1'b0;
            idx_r  <= '0;
            val_r  <= '0;
        end else if (clear) begin
            have_r <= 1'b0;
            idx_r  <= '0;
            val_r  <= '0;
        end else if (take_s) begin
            have_r <= 1'b1;
            idx_r  <= idx;
            val_r  <= value;
        end
    end

endmodule

// File: rtl/neuron_layer_seq.sv
// Fully-connected layer sequencer: walks neurons one by one, streams operand
// addresses to sync-read memories, strobes the shared MAC and captures sums.
// All outputs are registered; next values are derived from the next state.
module neuron_layer_seq
    import npu_pkg::*;
#(
    parameter int N_INPUTS  = 784,
    parameter int N_NEURONS = 10,
    parameter int XAW       = $clog2(N_INPUTS),
    parameter int NAW       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    parameter int WAW       = $clog2(N_INPUTS * N_NEURONS)
) (
    input  logic              CLKEXT,
    input  logic              RST,
    neuron_layer_seq_if.master bus
);

    localparam logic [XAW-1:0] J_LAST = XAW'(N_INPUTS - 1);
    localparam logic [XAW-1:0] J_PEN  = XAW'(N_INPUTS - 2);
    localparam logic [NAW-1:0] N_LAST = NAW'(N_NEURONS - 1);
    localparam logic [WAW-1:0] N_STEP = WAW'(N_INPUTS);

    state_t           state_r, state_s;
    logic [XAW-1:0]   j_r;
    logic [NAW-1:0]   n_r;
    logic [WAW-1:0]   base_r;

    logic             busy_r, busy_s, done_r, done_s;
    logic [XAW-1:0]   x_addr_r, x_addr_s;
    logic [WAW-1:0]   w_addr_r, w_addr_s;
    logic [NAW-1:0]   bias_addr_r, bias_addr_s;
    logic             rst_mac_r, rst_mac_s, en_mac_r, en_mac_s;
    logic             nvalid_r, nvalid_s;
    logic [NAW-1:0]   nidx_r, nidx_s, class_r, class_s;
    logic [ACC_W-1:0] nsum_r, nsum_s, max_r, max_s;

    logic             start_ok_s, capture_s;
    logic [NAW-1:0]   best_idx_s;
    logic [ACC_W-1:0] best_val_s;

    assign start_ok_s = (state_r == IDLE) && bus.START;
    assign capture_s  = (state_r == CAPTURE);

    argmax_tracker #(.IW(NAW), .VW(ACC_W)) u_argmax (
        .clk      (CLKEXT),
        .rst      (RST),
        .clear    (start_ok_s),
        .valid    (capture_s),
        .idx      (n_r),
        .value    (bus.MAC_RESULT),
        .best_idx (best_idx_s),
        .best_val (best_val_s)
    );

    // State register.
    always_ff @(posedge CLKEXT or posedge RST) begin
        if (RST) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = bus.START ? PREP : IDLE;
            PREP:    state_s = LOAD;
            LOAD:    state_s = STREAM;
            STREAM:  state_s = (j_r == J_LAST) ? CAPTURE : STREAM;
            CAPTURE: state_s = (n_r == N_LAST) ? FINISH : PREP;
            FINISH:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        busy_s      = (state_s != IDLE);
        done_s      = (state_s == FINISH);
        rst_mac_s   = (state_s == LOAD);
        en_mac_s    = (state_s == STREAM);
        nvalid_s    = capture_s;
        x_addr_s    = x_addr_r;
        w_addr_s    = w_addr_r;
        bias_addr_s = bias_addr_r;
        case (state_r)
            IDLE: begin
                if (bus.START) begin
                    x_addr_s    = '0;
                    w_addr_s    = '0;
                    bias_addr_s = '0;
                end else begin
                    x_addr_s    = x_addr_r;
                end
            end
            LOAD: begin
                x_addr_s = XAW'(1);
                w_addr_s = base_r + WAW'(1);
            end
            STREAM: begin
                // Stop advancing one short of the end so the address stays in range.
                if (j_r < J_PEN) begin
                    x_addr_s = x_addr_r + XAW'(1);
                    w_addr_s = w_addr_r + WAW'(1);
                end else begin
                    x_addr_s = x_addr_r;
                end
            end
            CAPTURE: begin
                if (n_r != N_LAST) begin
                    x_addr_s    = '0;
                    w_addr_s    = base_r + N_STEP;
                    bias_addr_s = n_r + NAW'(1);
                end else begin
                    x_addr_s    = x_addr_r;
                end
            end
            default: x_addr_s = x_addr_r;
        endcase
        if (capture_s) begin
            nsum_s = bus.MAC_RESULT;
            nidx_s = n_r;
        end else begin
            nsum_s = nsum_r;
            nidx_s = nidx_r;
        end
        if (capture_s && (n_r == N_LAST)) begin
            class_s = best_idx_s;
            max_s   = best_val_s;
        end else begin
            class_s = class_r;
            max_s   = max_r;
        end
    end

    // Operand, neuron and weight-base counters.
    always_ff @(posedge CLKEXT or posedge RST) begin
        if (RST) begin
            j_r    <= '0;
            n_r    <= '0;
            base_r <= '0;
        end else begin
            if (start_ok_s) begin
                n_r    <= '0;
                base_r <= '0;
            end else if (capture_s && (n_r != N_LAST)) begin
                n_r    <= n_r + NAW'(1);
                base_r <= base_r + N_STEP;
            end
            if (state_r == LOAD) begin
                j_r <= '0;
            end else if ((state_r == STREAM) && (j_r != J_LAST)) begin
                j_r <= j_r + XAW'(1);
            end
        end
    end

    // Output registers.
    always_ff @(posedge CLKEXT or posedge RST) begin
        if (RST) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            x_addr_r    <= '0;
            w_addr_r    <= '0;
            bias_addr_r <= '0;
            rst_mac_r   <= 1'b0;
            en_mac_r    <= 1'b0;
            nvalid_r    <= 1'b0;
            nidx_r      <= '0;
            nsum_r      <= '0;
            class_r     <= '0;
            max_r       <= '0;
        end else begin
            busy_r      <= busy_s;
            done_r      <= done_s;
            x_addr_r    <= x_addr_s;
            w_addr_r    <= w_addr_s;
            bias_addr_r <= bias_addr_s;
            rst_mac_r   <= rst_mac_s;
            en_mac_r    <= en_mac_s;
            nvalid_r    <= nvalid_s;
            nidx_r      <= nidx_s;
            nsum_r      <= nsum_s;
            class_r     <= class_s;
            max_r       <= max_s;
        end
    end

    assign bus.BUSY         = busy_r;
    assign bus.DONE         = done_r;
    assign bus.X_ADDR       = x_addr_r;
    assign bus.W_ADDR       = w_addr_r;
    assign bus.BIAS_ADDR    = bias_addr_r;
    assign bus.RST_MAC      = rst_mac_r;
    assign bus.EN_MAC       = en_mac_r;
    assign bus.NEURON_VALID = nvalid_r;
    assign bus.NEURON_IDX   = nidx_r;
    assign bus.NEURON_SUM   = nsum_r;
    assign bus.CLASS_OUT    = class_r;
    assign bus.MAX_OUT      = max_r;

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Directed bench for neuron_layer_seq with 4 inputs x 3 neurons, sync-read
// operand memories and a behavioural MAC.
module tb_neuron_layer_seq;

    logic clk;
    logic rst;

    neuron_layer_seq_if #(.XAW(2), .NAW(2), .WAW(4)) bus ();

    neuron_layer_seq #(.N_INPUTS(4), .N_NEURONS(3)) dut (
        .CLKEXT (clk),
        .RST    (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand memories (1-cycle read) and MAC model.
    logic [7:0]  x_mem [0:3];
    logic [7:0]  w_mem [0:11];
    logic [7:0]  b_mem [0:2];
    logic [7:0]  x_q, w_q, b_q;
    logic [15:0] acc;

    always @(posedge clk) begin
        x_q <= x_mem[bus.X_ADDR];
        w_q <= w_mem[bus.W_ADDR];
        b_q <= b_mem[bus.BIAS_ADDR];
        if (bus.RST_MAC)     acc <= {8'd0, b_q};
        else if (bus.EN_MAC) acc <= acc + x_q * w_q;
    end
    assign bus.MAC_RESULT = acc;

    int checks = 0;
    int errors = 0;

    logic [31:0] wtr [0:31];
    logic [31:0] xtr [0:31];
    logic [31:0] rtr [0:31];
    logic [31:0] etr [0:31];
    logic [31:0] btr [0:31];
    logic [31:0] ctr [0:31];
    logic [31:0] mtr [0:31];
    logic [31:0] batr [0:31];
    logic [31:0] vsum [0:3];
    logic [31:0] vidx [0:3];
    logic [31:0] vk   [0:3];
    int done_k, done_cnt, vcnt, both_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, 32'({bus.BUSY, bus.DONE, bus.RST_MAC, bus.EN_MAC, bus.NEURON_VALID}), 32'd0);
        chk({tag, "_addr"}, 32'({bus.X_ADDR, bus.W_ADDR, bus.BIAS_ADDR, bus.NEURON_IDX, bus.CLASS_OUT}), 32'd0);
        chk({tag, "_sum"},  32'(bus.NEURON_SUM), 32'd0);
        chk({tag, "_max"},  32'(bus.MAX_OUT), 32'd0);
    endtask

    task automatic set_bias(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        b_mem[0] = b0;
        b_mem[1] = b1;
        b_mem[2] = b2;
    endtask

    // Pulse START (called #1 after an edge) and record outputs for `limit` cycles.
    task automatic run_layer(input int limit, input int again_k);
        done_k = 0; done_cnt = 0; vcnt = 0; both_cnt = 0;
        bus.START = 1'b1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.START = 1'b0;
            if (again_k != 0 && k == again_k)     bus.START = 1'b1;
            if (again_k != 0 && k == again_k + 1) bus.START = 1'b0;
            wtr[k]  = 32'(bus.W_ADDR);
            xtr[k]  = 32'(bus.X_ADDR);
            rtr[k]  = 32'(bus.RST_MAC);
            etr[k]  = 32'(bus.EN_MAC);
            btr[k]  = 32'(bus.BUSY);
            ctr[k]  = 32'(bus.CLASS_OUT);
            mtr[k]  = 32'(bus.MAX_OUT);
            batr[k] = 32'(bus.BIAS_ADDR);
            if (bus.RST_MAC && bus.EN_MAC) both_cnt++;
            if (bus.NEURON_VALID) begin
                if (vcnt < 4) begin
                    vsum[vcnt] = 32'(bus.NEURON_SUM);
                    vidx[vcnt] = 32'(bus.NEURON_IDX);
                    vk[vcnt]   = 32'(k);
                end
                vcnt++;
            end
            if (bus.DONE) begin
                if (done_k == 0) done_k = k;
                done_cnt++;
            end
        end
    endtask

    int rcount, ecount;

    initial begin
        for (int i = 0; i < 4; i++)  x_mem[i] = 8'(i + 1);
        for (int i = 0; i < 12; i++) w_mem[i] = 8'd1;
        set_bias(8'd0, 8'd5, 8'd2);
        acc = 16'd0;
        bus.START = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic layer: sums 10,15,12 -> class 1, max 15.
        run_layer(30, 0);
        chk("basic_done_k",   32'(done_k), 32'd22);
        chk("basic_done_cnt", 32'(done_cnt), 32'd1);
        chk("basic_vcnt",     32'(vcnt), 32'd3);
        chk("basic_sum0", vsum[0], 32'd10);
        chk("basic_sum1", vsum[1], 32'd15);
        chk("basic_sum2", vsum[2], 32'd12);
        chk("basic_idx0", vidx[0], 32'd0);
        chk("basic_idx1", vidx[1], 32'd1);
        chk("basic_idx2", vidx[2], 32'd2);
        chk("basic_vk0",  vk[0], 32'd8);
        chk("basic_vk2",  vk[2], 32'd22);
        chk("basic_class", 32'(bus.CLASS_OUT), 32'd1);
        chk("basic_max",   32'(bus.MAX_OUT), 32'd15);
        chk("busy_first",  btr[1], 32'd1);
        chk("busy_done",   btr[22], 32'd1);
        chk("busy_after",  btr[23], 32'd0);
        chk("both_high",   32'(both_cnt), 32'd0);

        // Address trace across neuron 1 (cycles 8..14).
        chk("w_prep",  wtr[8],  32'd4);
        chk("w_load",  wtr[9],  32'd4);
        chk("w_s0",    wtr[10], 32'd5);
        chk("w_s1",    wtr[11], 32'd6);
        chk("w_s2",    wtr[12], 32'd7);
        chk("w_s3",    wtr[13], 32'd7);
        chk("x_s0",    xtr[10], 32'd1);
        chk("x_s3",    xtr[13], 32'd3);
        chk("bias_n1", batr[8], 32'd1);
        rcount = 0; ecount = 0;
        for (int k = 8; k <= 14; k++) begin
            rcount += int'(rtr[k]);
            ecount += int'(etr[k]);
        end
        chk("rst_mac_n1", 32'(rcount), 32'd1);
        chk("rst_mac_at", rtr[9], 32'd1);
        chk("en_mac_n1",  32'(ecount), 32'd4);
        chk("en_mac_run", {etr[10][0], etr[11][0], etr[12][0], etr[13][0]}, 32'hF);

        // Tie with START pulsed while busy.
        set_bias(8'd7, 8'd7, 8'd0);
        run_layer(30, 5);
        chk("tie_done_k",   32'(done_k), 32'd22);
        chk("tie_done_cnt", 32'(done_cnt), 32'd1);
        chk("tie_class", 32'(bus.CLASS_OUT), 32'd0);
        chk("tie_max",   32'(bus.MAX_OUT), 32'd17);

        // Reset during neuron 1 STREAM, then a clean run.
        set_bias(8'd0, 8'd5, 8'd2);
        run_layer(11, 0);
        chk("partial_no_done", 32'(done_cnt), 32'd0);
        rst = 1'b1;
        #1;
        check_zero("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_layer(30, 0);
        chk("rerun_done_k", 32'(done_k), 32'd22);
        chk("rerun_sum1",   vsum[1], 32'd15);
        chk("rerun_class",  32'(bus.CLASS_OUT), 32'd1);
        chk("rerun_max",    32'(bus.MAX_OUT), 32'd15);

        // Back-to-back: second START in the cycle after DONE.
        run_layer(22, 0);
        chk("b2b_first_done", 32'(done_k), 32'd22);
        @(posedge clk); #1;
        chk("b2b_idle_busy", 32'(bus.BUSY), 32'd0);
        chk("b2b_old_class", 32'(bus.CLASS_OUT), 32'd1);
        set_bias(8'd7, 8'd7, 8'd0);
        run_layer(22, 0);
        chk("b2b_busy1",     btr[1], 32'd1);
        chk("b2b_hold_cls",  ctr[21], 32'd1);
        chk("b2b_hold_max",  mtr[21], 32'd15);
        chk("b2b_done_k",    32'(done_k), 32'd22);
        chk("b2b_new_class", 32'(bus.CLASS_OUT), 32'd0);
        chk("b2b_new_max",   32'(bus.MAX_OUT), 32'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_layer_seq.md
# neuron_layer_seq

Sequencer for the shared 8-bit MAC datapath of the NPU. It walks one fully-connected layer neuron by neuron. For each neuron it fetches the bias, input and weight operands from synchronous-read memories, drives the MAC's bias-load and enable controls, and captures each 16-bit neuron sum. It keeps a running argmax over all sums, so at the final layer it reports the classified MNIST digit.

## Interface
- N_INPUTS, default 784: inputs per neuron (operand pairs accumulated); ≥ 2.
- N_NEURONS, default 10: neurons in the layer; ≥ 1.
- XAW, default $clog2(N_INPUTS): input-memory address width.
- NAW, default $clog2(N_NEURONS) (min 1): neuron/bias address width.
- WAW, default $clog2(N_INPUTS*N_NEURONS): weight-memory address width.

Ports:
- CLKEXT  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- START  in  1  one-cycle request to run the layer.
- BUSY  out  1  high from the cycle after an accepted START until DONE.
- DONE  out  1  one-cycle pulse, layer finished.
- X_ADDR  out  XAW  input-memory address (data valid next cycle).
- W_ADDR  out  WAW  weight-memory address (data valid next cycle).
- BIAS_ADDR  out  NAW  bias-memory address (data valid next cycle).
- RST_MAC  out  1  MAC bias-load/clear strobe.
- EN_MAC  out  1  MAC operand enable.
- MAC_RESULT  in  16  MAC accumulator output.
- NEURON_VALID  out  1  one-cycle pulse, NEURON_SUM valid.
- NEURON_IDX  out  NAW  index of the captured neuron.
- NEURON_SUM  out  16  captured neuron sum.
- CLASS_OUT  out  NAW  argmax neuron index, valid with DONE and held.
- MAX_OUT  out  16  maximum sum, valid with DONE and held.

## Operation
- States:
  - IDLE
  - PREP: BIAS_ADDR=n, X_ADDR=0, W_ADDR=n*N_INPUTS.
  - LOAD: RST_MAC=1, addresses held at i=0.
  - STREAM: EN_MAC=1, runs N_INPUTS cycles.
  - CAPTURE
  - FINISH
- Transitions:
  - IDLE→PREP on START, with n=0.
  - PREP→LOAD→STREAM.
  - STREAM→CAPTURE after cycle j=N_INPUTS-1.
  - CAPTURE→PREP with n+1 if n<N_NEURONS-1, else →FINISH.
  - FINISH→IDLE.
- In STREAM cycle j:
  - X_ADDR=j+1 and W_ADDR=n*N_INPUTS+j+1.
  - Operand j is on the memory outputs.
  - In the final cycle the addresses hold at j=N_INPUTS-1; the out-of-range address is never issued.
- W_ADDR is produced by an incrementing counter with a per-neuron base register. No multiplier.
- CAPTURE:
  - NEURON_SUM←MAC_RESULT, NEURON_IDX←n, NEURON_VALID=1.
  - Argmax update: n==0 loads unconditionally; afterwards update only on a strictly greater unsigned sum, so ties keep the lower index.
- FINISH: DONE=1; CLASS_OUT and MAX_OUT latched and held until the next START.
- START is ignored when not in IDLE. Simultaneous START and FINISH: the START is ignored.
- Overflow is not detected; the 16-bit wrap is the MAC's behaviour.
- RST at any time, including mid-layer:
  - State returns to IDLE.
  - Every output goes to 0.
  - Counters and argmax registers are cleared.
  - No partial DONE is produced.

## Timing
- Reset value of every output is 0.
- Per neuron: N_INPUTS+3 cycles (PREP 1, LOAD 1, STREAM N_INPUTS, CAPTURE 1).
- Layer latency, from the START edge to the DONE pulse: N_NEURONS*(N_INPUTS+3)+1 cycles. With defaults: 7871.
- RST_MAC and EN_MAC are registered outputs, never high in the same cycle.
- Memory read latency is fixed at exactly 1 cycle and there is no back-pressure.
- BUSY falls in the cycle after DONE. START is accepted again from that cycle.

## Structure
- Shared package npu_pkg holds the state enum type (IDLE, PREP, LOAD, STREAM, CAPTURE, FINISH) and the 16-bit accumulator width constant ACC_W.
- Sub-module argmax_tracker contains the compare/update registers.
  - Inputs: clear, valid, idx, value.
  - Outputs: class, max.
- Counters (j, n, weight base) and the FSM live in the top.

## Test plan
Bench uses N_INPUTS=4, N_NEURONS=3, a behavioural MAC model and sync-read memories.

- **Basic layer.** Inputs 1,2,3,4; weights all 1; biases 0,5,2.
  - Three NEURON_VALID pulses: sums 10, 15, 12 at idx 0, 1, 2.
  - DONE at cycle 22 after START, with CLASS_OUT=1 and MAX_OUT=15.
- **Tie.** Biases 7,7,0.
  - Result: CLASS_OUT=0, MAX_OUT=17.
- **Address trace.** Check per-cycle values across the neuron-1 window.
  - W_ADDR sequence 4,4,5,6,7,7.
  - RST_MAC exactly 1 cycle.
  - EN_MAC exactly 4 consecutive cycles.
- **START while busy.** Pulse START at cycle 5.
  - Ignored; exactly one DONE; latency unchanged.
- **Reset mid-layer.** Assert RST during neuron 1 STREAM.
  - All outputs 0 immediately.
  - A fresh START afterwards yields a correct full result.
- **Back-to-back runs.** Pulse START in the cycle after DONE.
  - Second run accepted; CLASS_OUT holds the old value until the new DONE.
